// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and helpers for the I2S microphone array controller
package i2s_pkg;

   localparam int SAMPLE_W = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } bus_state_e;

   // Round-robin successor of idx among n channels
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/i2s_bus_gen.sv
// rtl/i2s_bus_gen.sv - SCK/WS/frame generator with frame-aligned stop
module i2s_bus_gen
   import i2s_pkg::*;
#(
   parameter int CLK_DIV   = 16,
   parameter int SLOT_BITS = 32
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic enable_i,
   output logic sck_o,
   output logic ws_o,
   output logic frame_o
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(2 * SLOT_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
   localparam logic [BIT_W-1:0] WS_START = BIT_W'(SLOT_BITS);

   bus_state_e       state, state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic [BIT_W-1:0] bit_cnt, bit_nxt;
   logic             tc, fall, wrap;

   // A falling SCK toggle is a terminal count while SCK is high; wrap ends the frame
   assign tc      = (div_cnt == DIV_LAST);
   assign fall    = tc & sck_o;
   assign wrap    = fall & (bit_cnt == BIT_LAST);
   assign bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;

   // Next state: leave IDLE on enable, finish the current frame on disable
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (enable_i) state_nxt = RUN;
         RUN:     if (!enable_i) state_nxt = DRAIN;
         DRAIN: begin
            if (enable_i)  state_nxt = RUN;
            else if (wrap) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   // Divider, bit counter and registered bus outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         sck_o   <= 1'b0;
         ws_o    <= 1'b0;
         frame_o <= 1'b0;
      end else if (state_nxt == IDLE) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         sck_o   <= 1'b0;
         ws_o    <= 1'b0;
         frame_o <= 1'b0;
      end else if (state == IDLE) begin
         // fresh frame: bit 0, left slot
         div_cnt <= '0;
         bit_cnt <= '0;
         sck_o   <= 1'b0;
         ws_o    <= 1'b0;
         frame_o <= 1'b1;
      end else begin
         if (tc) begin
            div_cnt <= '0;
            sck_o   <= ~sck_o;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         if (fall) begin
            bit_cnt <= bit_nxt;
            ws_o    <= (bit_nxt >= WS_START);
         end
         frame_o <= wrap;
      end
   end

endmodule

// File: rtl/i2s_array_ctrl.sv
// rtl/i2s_array_ctrl.sv - multi-mic I2S bus control with round-robin sample scheduling
module i2s_array_ctrl
   import i2s_pkg::*;
#(
   parameter int  N_MICS    = 4,
   parameter int  CLK_DIV   = 16,
   parameter int  SLOT_BITS = 32,
   localparam int CHAN_W    = (N_MICS > 1) ? $clog2(N_MICS) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         enable_i,
   output logic                         sck_o,
   output logic                         ws_o,
   output logic                         frame_o,
   input  logic [N_MICS*SAMPLE_W-1:0]   cap_data_i,
   input  logic [N_MICS-1:0]            cap_valid_i,
   output logic [SAMPLE_W-1:0]          m_data_o,
   output logic [CHAN_W-1:0]            m_chan_o,
   output logic                         m_valid_o,
   input  logic                         m_ready_i,
   output logic                         overrun_o,
   input  logic                         clear_i
);

   logic [SAMPLE_W-1:0] hold [N_MICS];
   logic [N_MICS-1:0]   pending;
   logic [N_MICS-1:0]   grant_mask;
   logic [CHAN_W-1:0]   last_grant, grant_idx;
   logic                grant_vld, loadable, ovr_evt;

   i2s_bus_gen #(
      .CLK_DIV   (CLK_DIV),
      .SLOT_BITS (SLOT_BITS)
   ) u_bus_gen (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .enable_i (enable_i),
      .sck_o    (sck_o),
      .ws_o     (ws_o),
      .frame_o  (frame_o)
   );

   assign loadable = !m_valid_o || m_ready_i;

   // Round-robin search for the first pending channel after last_grant
   always_comb begin
      int idx;
      idx       = rr_next(int'(last_grant), N_MICS);
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < N_MICS; i++) begin
         if (!grant_vld && pending[CHAN_W'(idx)]) begin
            grant_vld = 1'b1;
            grant_idx = CHAN_W'(idx);
         end
         idx = rr_next(idx, N_MICS);
      end
   end

   // One-hot of the channel actually handed to the output this cycle
   always_comb begin
      grant_mask = '0;
      if (loadable && grant_vld) grant_mask[grant_idx] = 1'b1;
   end

   // A refill racing its own grant is not an overrun
   assign ovr_evt = |(cap_valid_i & pending & ~grant_mask);

   // Pending flags: a new capture always wins over the grant clearing it
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pending <= '0;
      else         pending <= cap_valid_i | (pending & ~grant_mask);
   end

   // Per-channel hold registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < N_MICS; k++) hold[k] <= '0;
      end else begin
         for (int k = 0; k < N_MICS; k++)
            if (cap_valid_i[k]) hold[k] <= cap_data_i[k*SAMPLE_W +: SAMPLE_W];
      end
   end

   // Output register: loads on a free slot, otherwise holds for backpressure
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_valid_o  <= 1'b0;
         m_data_o   <= '0;
         m_chan_o   <= '0;
         last_grant <= CHAN_W'(N_MICS - 1);
      end else if (loadable) begin
         m_valid_o <= grant_vld;
         if (grant_vld) begin
            m_data_o   <= hold[grant_idx];
            m_chan_o   <= grant_idx;
            last_grant <= grant_idx;
         end
      end
   end

   // Sticky overrun; a new event beats a simultaneous clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) overrun_o <= 1'b0;
      else         overrun_o <= ovr_evt | (overrun_o & ~clear_i);
   end

endmodule

// File: tb/tb_i2s_array_ctrl.sv
// tb/tb_i2s_array_ctrl.sv - randomized self-checking bench for i2s_array_ctrl
module tb_i2s_array_ctrl;

   localparam int N     = 4;
   localparam int CD    = 16;
   localparam int SB    = 32;
   localparam int FRAME = 2 * SB * 2 * CD;

   logic          clk, rst_n, en, clr, rdy;
   logic [N*24-1:0] cd;
   logic [N-1:0]  cv;
   logic          sck, ws, frame, m_valid, overrun;
   logic [23:0]   m_data;
   logic [1:0]    m_chan;

   int vec_cnt = 0;
   int err_cnt = 0;

   // reference state
   bit          bus_on;
   int          t, stop_t;
   logic [23:0] mhold [N];
   bit          mpend [N];
   int          mlast, mc;
   bit          mv, movr;
   logic [23:0] md;

   i2s_array_ctrl #(.N_MICS(N), .CLK_DIV(CD), .SLOT_BITS(SB)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .enable_i    (en),
      .sck_o       (sck),
      .ws_o        (ws),
      .frame_o     (frame),
      .cap_data_i  (cd),
      .cap_valid_i (cv),
      .m_data_o    (m_data),
      .m_chan_o    (m_chan),
      .m_valid_o   (m_valid),
      .m_ready_i   (rdy),
      .overrun_o   (overrun),
      .clear_i     (clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int cur_bit();
      return (t / (2 * CD)) % (2 * SB);
   endfunction

   task automatic model_reset();
      bus_on = 0; t = 0; stop_t = -1;
      for (int k = 0; k < N; k++) begin mhold[k] = '0; mpend[k] = 0; end
      mlast = N - 1; mv = 0; md = '0; mc = 0; movr = 0;
   endtask

   // One clock edge of the reference, using the inputs present at that edge
   task automatic model_step();
      bit found, ovr, loadable;
      int g, j;
      if (!bus_on) begin
         if (en) begin bus_on = 1; t = 0; stop_t = -1; end
      end else begin
         t++;
         if (en) stop_t = -1;
         else if (stop_t < 0) stop_t = (t / FRAME + 1) * FRAME;
         if (stop_t >= 0 && t == stop_t) bus_on = 0;
      end
      loadable = !mv || rdy;
      found = 0; g = 0;
      if (loadable)
         for (int i = 1; i <= N; i++) begin
            j = (mlast + i) % N;
            if (!found && mpend[j]) begin found = 1; g = j; end
         end
      ovr = 0;
      for (int k = 0; k < N; k++)
         if (cv[k] && mpend[k] && !(found && g == k)) ovr = 1;
      if (loadable) begin
         mv = found;
         if (found) begin md = mhold[g]; mc = g; mlast = g; mpend[g] = 0; end
      end
      for (int k = 0; k < N; k++)
         if (cv[k]) begin mhold[k] = cd[k*24 +: 24]; mpend[k] = 1; end
      movr = ovr || (movr && !clr);
   endtask

   task automatic compare_all();
      check("sck",     32'(sck),     32'(bus_on ? (t / CD) % 2 : 0));
      check("ws",      32'(ws),      32'(bus_on && cur_bit() >= SB));
      check("frame",   32'(frame),   32'(bus_on && (t % FRAME) == 0));
      check("m_valid", 32'(m_valid), 32'(mv));
      check("m_data",  32'(m_data),  32'(md));
      check("m_chan",  32'(m_chan),  32'(mc));
      check("overrun", 32'(overrun), 32'(movr));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic rand_cycle(input int pv);
      for (int k = 0; k < N; k++) cv[k] = ($urandom_range(pv - 1) == 0);
      rdy = ($urandom_range(3) != 0);
      clr = ($urandom_range(31) == 0);
      cd  = {$urandom(), $urandom(), $urandom()};
      step();
      cv = '0; clr = 1'b0;
   endtask

   // Asynchronous reset applied between edges
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;
   endtask

   logic [23:0] rr_data [N];
   bit          hit;

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; rdy = 1'b1; cv = '0; cd = '0;
      #3;
      do_reset();
      repeat (5) step();

      // start the bus
      en = 1'b1;
      repeat (20) step();

      // round-robin ordering
      rr_data[0] = 24'hABCDEF; rr_data[1] = 24'h123456;
      rr_data[2] = 24'h000001; rr_data[3] = 24'hFFFFFF;
      cd = {rr_data[3], rr_data[2], rr_data[1], rr_data[0]};
      cv = 4'b1111; rdy = 1'b1;
      step();
      cv = '0;
      for (int i = 0; i < N; i++) begin
         step();
         check("rr_valid", 32'(m_valid), 32'd1);
         check("rr_chan",  32'(m_chan),  32'(i));
         check("rr_data",  32'(m_data),  32'(rr_data[i]));
      end
      repeat (3) step();

      // backpressure: ch0 stalls in output, ch2 pending then overwritten
      rdy = 1'b0;
      cd = {24'h0, 24'h2A2A2A, 24'h0, 24'h0F0F0F};
      cv = 4'b0001; step(); cv = '0; step();
      cv = 4'b0100; step(); cv = '0;
      for (int i = 0; i < 50; i++) begin
         if (i == 25) begin cd[2*24 +: 24] = 24'h555555; cv = 4'b0100; end
         step();
         cv = '0;
         check("stall_chan", 32'(m_chan), 32'd0);
         check("stall_data", 32'(m_data), 32'h0F0F0F);
      end
      check("ovr_set", 32'(overrun), 32'd1);
      rdy = 1'b1; clr = 1'b1; step(); clr = 1'b0;
      check("ovr_clear", 32'(overrun), 32'd0);
      repeat (6) step();

      // same-cycle grant and refill on ch1
      cd[1*24 +: 24] = 24'hA1A1A1; cv = 4'b0010; step();
      cd[1*24 +: 24] = 24'hB2B2B2; cv = 4'b0010; step(); cv = '0;
      check("refill_old", 32'(m_data), 32'hA1A1A1);
      step();
      check("refill_new", 32'(m_data), 32'hB2B2B2);
      check("refill_chan", 32'(m_chan), 32'd1);
      check("refill_ovr", 32'(overrun), 32'd0);

      // randomized traffic
      for (int i = 0; i < 2500; i++) rand_cycle(8);

      // drain from bit 40
      hit = 0;
      for (int i = 0; i < 3 * FRAME && !hit; i++) begin
         rand_cycle(16);
         if (bus_on && cur_bit() == 40) hit = 1;
      end
      check("reach_bit40", 32'(hit), 32'd1);
      en = 1'b0;
      for (int i = 0; i < 2 * FRAME && bus_on; i++) rand_cycle(16);
      check("drain_done", 32'(bus_on), 32'd0);
      repeat (200) rand_cycle(16);
      check("idle_sck", 32'(sck), 32'd0);
      check("idle_ws",  32'(ws),  32'd0);

      // reset mid-frame with two samples pending
      en = 1'b1; rdy = 1'b1;
      repeat (10) step();
      rdy = 1'b0;
      cv = 4'b1011; cd = {$urandom(), $urandom(), $urandom()}; step(); cv = '0; step();
      hit = 0;
      for (int i = 0; i < 3 * FRAME && !hit; i++) begin
         step();
         if (bus_on && cur_bit() == 20) hit = 1;
      end
      check("reach_bit20", 32'(hit), 32'd1);
      en = 1'b0;
      do_reset();
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_sck",   32'(sck),     32'd0);
      repeat (5) step();
      rdy = 1'b1; en = 1'b1;
      step();
      check("restart_frame", 32'(frame), 32'd1);
      check("restart_valid", 32'(m_valid), 32'd0);
      for (int i = 0; i < FRAME + 60; i++) rand_cycle(8);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
